// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC capture sequencer.
package adc_capture_pkg;

  localparam int SAMPLE_W = 18;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  localparam logic [1:0] TRIG_IMM = 2'd0;
  localparam logic [1:0] TRIG_EXT = 2'd1;
  localparam logic [1:0] TRIG_THR = 2'd2;

endpackage

// File: rtl/adc_trig_detect.sv
// Trigger qualification: latched ext_trig rising edge, or signed threshold
// rising crossing against the previous sample; trig_hit is same-cycle.
module adc_trig_detect
  import adc_capture_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       armed,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic signed [SAMPLE_W-1:0] threshold,
  input  logic [1:0]                 trig_mode,
  input  logic                       ext_trig,
  output logic                       trig_hit
);

  logic                       ext_q;
  logic                       ext_edge;
  logic                       edge_seen;
  logic                       prev_vld;
  logic signed [SAMPLE_W-1:0] prev;
  logic                       cond;

  assign ext_edge = ext_trig & ~ext_q;

  // Edge latch and prev sample only live while armed, so leaving ARMED discards them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q     <= 1'b0;
      edge_seen <= 1'b0;
      prev_vld  <= 1'b0;
      prev      <= '0;
    end else begin
      ext_q     <= ext_trig;
      edge_seen <= armed & (edge_seen | ext_edge);
      if (!armed) begin
        prev_vld <= 1'b0;
      end else if (sample_valid) begin
        prev     <= sample;
        prev_vld <= 1'b1;
      end
    end
  end

  always_comb begin
    cond = 1'b1;
    case (trig_mode)
      TRIG_EXT: cond = edge_seen | ext_edge;
      TRIG_THR: cond = prev_vld && (prev < threshold) && (sample >= threshold);
      default:  cond = 1'b1;
    endcase
  end

  assign trig_hit = armed & sample_valid & cond;

endmodule

// File: rtl/adc_capture_seq.sv
// Armed/triggered capture sequencer: decimates the conversion stream and
// writes a fixed-length run of normalised 18-bit samples into capture RAM.
module adc_capture_seq
  import adc_capture_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                bits_18,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          trig_mode,
  input  logic                ext_trig,
  input  logic [SAMPLE_W-1:0] threshold,
  input  logic [ADDR_W-1:0]   depth,
  input  logic [7:0]          decim,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [SAMPLE_W-1:0] wr_data,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state
);

  function automatic logic signed [SAMPLE_W-1:0] normalise(
    input logic [SAMPLE_W-1:0] s,
    input logic                is_18
  );
    return is_18 ? $signed(s) : $signed({{2{s[15]}}, s[15:0]});
  endfunction

  cap_state_t                 state_q, state_d;
  logic [ADDR_W-1:0]          depth_q, addr_cnt;
  logic [7:0]                 decim_q, dec_cnt;
  logic signed [SAMPLE_W-1:0] data_p0;
  logic                       trig_hit, wr_now, arm;

  assign data_p0 = normalise(sample, bits_18);
  assign state   = state_q;

  adc_trig_detect u_trig (
    .clk          (clk),
    .rst_n        (rst_n),
    .armed        (state_q == ARMED),
    .sample_valid (sample_valid),
    .sample       (data_p0),
    .threshold    ($signed(threshold)),
    .trig_mode    (trig_mode),
    .ext_trig     (ext_trig),
    .trig_hit     (trig_hit)
  );

  // addr_cnt reaching depth_q marks the run full; DONE follows one cycle after the last write.
  always_comb begin
    state_d = state_q;
    wr_now  = 1'b0;
    arm     = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          arm     = 1'b1;
          state_d = (depth == '0) ? DONE : ARMED;
        end
        ARMED: if (trig_hit) begin
          wr_now  = 1'b1;
          state_d = CAPTURE;
        end
        CAPTURE: begin
          if (addr_cnt == depth_q) state_d = DONE;
          else if (sample_valid && dec_cnt == 8'd0) wr_now = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // p1: registered write port and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      depth_q  <= '0;
      decim_q  <= '0;
      addr_cnt <= '0;
      dec_cnt  <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == ARMED) || (state_d == CAPTURE);
      done    <= (state_d == DONE);
      wr_en   <= wr_now;
      if (wr_now) begin
        wr_addr  <= addr_cnt;
        wr_data  <= data_p0;
        addr_cnt <= addr_cnt + 1'b1;
      end
      if (arm) begin
        depth_q  <= depth;
        decim_q  <= decim;
        addr_cnt <= '0;
        dec_cnt  <= '0;
      end else if (state_q == ARMED && wr_now) begin
        dec_cnt <= (decim_q == 8'd0) ? 8'd0 : 8'd1;
      end else if (state_q == CAPTURE && sample_valid) begin
        dec_cnt <= (dec_cnt == decim_q) ? 8'd0 : dec_cnt + 8'd1;
      end
    end
  end

endmodule
